stim_pattern_player: RTL and testbench

Parametrised stimulus source that replaces hand-written initial-block stimulus with a loadable pattern memory played out over a valid/ready stream.
- Patterns are written through a simple write port, then replayed in one-shot, loop or ping-pong order.
- Sits between the bench/config host and the DUT input bus.
- Generalises the fixed 8-bit single-shot stimulus to arbitrary width, depth and play modes, and adds backpressure.

---
 rtl/stim_pkg.sv | 13 +
 rtl/stim_pattern_ram.sv | 28 ++
 rtl/stim_pattern_player.sv | 171 +++++++++++++++++
 tb/tb_stim_pattern_player.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared constants and types for the stimulus pattern player.
package stim_pkg;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_LOOP     = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_t;

endpackage

// File: rtl/stim_pattern_ram.sv
// Pattern store: one synchronous write port, one combinational read port.
// A read in the same cycle as a write to that address sees the old word,
// because the new word only lands on the clock edge.
module stim_pattern_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the word; addresses beyond the array are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stim_pattern_player.sv
// Pattern player: replays the stored pattern over a valid/ready stream in
// one-shot, loop or ping-pong order.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | waiting for start; outputs idle, loop_count holds last result
//  S_PLAY | presenting beats; advances index on every accepted beat
module stim_pattern_player
  import stim_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int LCW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    last_idx,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [LCW-1:0]   loop_count
);

  state_t           state;
  logic [1:0]       mode_q;
  logic [AW-1:0]    last_q;
  logic [AW-1:0]    idx;
  logic             dir_up;
  logic             stop_pending;

  logic [AW-1:0]    last_clamp;
  logic [AW-1:0]    nxt_idx;
  logic             nxt_up;
  logic             wrap;
  logic             fin;
  logic             accept;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  stim_pattern_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign last_clamp = ({1'b0, last_idx} >= (AW+1)'(DEPTH)) ? AW'(DEPTH - 1) : last_idx;
  assign accept     = out_valid && out_ready;
  // Idle only ever loads entry 0 (on start); in play we prefetch the next beat.
  assign rd_addr    = (state == S_IDLE) ? '0 : nxt_idx;

  // Next index/direction for the current mode, plus pass-complete and end flags.
  always_comb begin
    nxt_idx = idx;
    nxt_up  = dir_up;
    wrap    = 1'b0;
    fin     = 1'b0;
    case (mode_q)
      MODE_LOOP: begin
        if (idx == last_q) begin
          nxt_idx = '0;
          wrap    = 1'b1;
        end else begin
          nxt_idx = idx + 1'b1;
        end
      end
      MODE_PINGPONG: begin
        if (last_q == '0) begin
          nxt_idx = '0;
          wrap    = 1'b1;
        end else begin
          if (dir_up && (idx != last_q)) begin
            nxt_idx = idx + 1'b1;
          end else begin
            nxt_idx = idx - 1'b1;
            nxt_up  = 1'b0;
          end
          // Arriving back at entry 0 closes a pass and turns around.
          if (nxt_idx == '0) begin
            wrap   = 1'b1;
            nxt_up = 1'b1;
          end
        end
      end
      default: begin
        if (idx == last_q) begin
          fin = 1'b1;
        end else begin
          nxt_idx = idx + 1'b1;
        end
      end
    endcase
  end

  // Sequencer: start/stop handling, beat advance and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      mode_q       <= MODE_ONESHOT;
      last_q       <= '0;
      idx          <= '0;
      dir_up       <= 1'b1;
      stop_pending <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      loop_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q       <= ((mode == MODE_LOOP) || (mode == MODE_PINGPONG)) ? mode : MODE_ONESHOT;
            last_q       <= last_clamp;
            idx          <= '0;
            dir_up       <= 1'b1;
            loop_count   <= '0;
            stop_pending <= 1'b0;
            out_data     <= rd_data;
            out_valid    <= 1'b1;
            busy         <= 1'b1;
            state        <= S_PLAY;
          end
        end
        default: begin
          if (stop) begin
            stop_pending <= 1'b1;
          end
          if (accept) begin
            if (fin) begin
              out_valid    <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              stop_pending <= 1'b0;
              state        <= S_IDLE;
            end else if (stop || stop_pending) begin
              out_valid    <= 1'b0;
              busy         <= 1'b0;
              stop_pending <= 1'b0;
              state        <= S_IDLE;
            end else begin
              idx      <= nxt_idx;
              dir_up   <= nxt_up;
              out_data <= rd_data;
              if (wrap && (loop_count != '1)) begin
                loop_count <= loop_count + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stim_pattern_player.sv
// Bench for stim_pattern_player: directed scenarios with literal expectations
// plus a long randomized run, all checked against a sequence-level model.
module tb_stim_pattern_player;
  import stim_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int LCW   = 8;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [AW-1:0]    last_idx;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [LCW-1:0]   loop_count;

  stim_pattern_player #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW),
    .LCW   (LCW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .last_idx   (last_idx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .loop_count (loop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a play session is just "beat number k" mapped to an index by the
  // mode's ordering rule; loop_count is the number of completed passes.
  logic [WIDTH-1:0] smem [DEPTH];
  bit               m_play, m_valid, m_done, m_sp;
  int               m_L, m_md, m_k, m_cnt;
  logic [WIDTH-1:0] m_data;

  function automatic int idx_of(input int md, input int L, input int k);
    int p;
    if (md == 1) return k % (L + 1);
    if (md == 2) begin
      if (L == 0) return 0;
      p = k % (2 * L);
      return (p <= L) ? p : 2 * L - p;
    end
    return k;
  endfunction

  function automatic int cnt_of(input int md, input int L, input int k);
    int c;
    c = 0;
    if (md == 1) c = k / (L + 1);
    if (md == 2) c = (L == 0) ? k : k / (2 * L);
    return (c > 255) ? 255 : c;
  endfunction

  initial begin
    m_play = 0; m_valid = 0; m_done = 0; m_sp = 0;
    m_L = 0; m_md = 0; m_k = 0; m_cnt = 0; m_data = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_play = 0; m_valid = 0; m_done = 0; m_sp = 0; m_cnt = 0; m_data = '0;
    end else begin
      m_done = 0;
      if (!m_play) begin
        if (start) begin
          m_L     = (int'(last_idx) >= DEPTH) ? DEPTH - 1 : int'(last_idx);
          m_md    = (mode == 2'd1 || mode == 2'd2) ? int'(mode) : 0;
          m_k     = 0;
          m_cnt   = 0;
          m_sp    = 0;
          m_data  = smem[0];
          m_valid = 1;
          m_play  = 1;
        end
      end else begin
        if (stop) m_sp = 1;
        if (m_valid && out_ready) begin
          if (m_md == 0 && idx_of(m_md, m_L, m_k) == m_L) begin
            m_valid = 0; m_done = 1; m_play = 0;
          end else if (m_sp) begin
            m_valid = 0; m_play = 0;
          end else begin
            m_k++;
            m_data = smem[idx_of(m_md, m_L, m_k)];
            m_cnt  = cnt_of(m_md, m_L, m_k);
          end
        end
      end
    end
    // Applied after the load above: a same-edge write is seen on the next read.
    if (wr_en && int'(wr_addr) < DEPTH) smem[wr_addr] = wr_data;
  end

  // Per-cycle comparison against the model, away from the active edge.
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", out_valid, m_valid);
      chk("busy", busy, m_play);
      chk("done", done, m_done);
      chk("loop_count", loop_count, m_cnt);
      if (m_valid) chk("data", out_data, m_data);
    end
  end

  logic [7:0] lit [4];
  int pp [7];

  task automatic write_word(input int a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic play(input logic [1:0] md, input int L);
    mode = md; last_idx = AW'(L); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stop_play();
    out_ready = 1'b1; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    chk("stopped_valid", out_valid, 0);
  endtask

  initial begin
    lit = '{8'h11, 8'h22, 8'h33, 8'h44};
    pp  = '{0, 1, 2, 1, 0, 1, 2};
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; mode = 2'd0; last_idx = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_loop_count", loop_count, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;
    chk_en = 1;

    for (int a = 0; a < DEPTH; a++) write_word(a, (a < 4) ? lit[a] : 8'($urandom));

    // One-shot over four entries at full throughput.
    out_ready = 1'b1;
    play(MODE_ONESHOT, 3);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", out_data, lit[i]);
      chk("t1_valid", out_valid, 1);
      @(negedge clk);
    end
    chk("t1_done", done, 1);
    chk("t1_valid_end", out_valid, 0);
    chk("t1_busy_end", busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    // Loop over two entries, then random backpressure.
    play(MODE_LOOP, 1);
    for (int i = 0; i < 6; i++) begin
      chk("t2_data", out_data, lit[i % 2]);
      @(negedge clk);
    end
    chk("t2_loop_count", loop_count, 3);
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'($urandom);
      @(negedge clk);
    end
    stop_play();

    // Ping-pong, then the degenerate single-entry ping-pong.
    play(MODE_PINGPONG, 2);
    for (int i = 0; i < 7; i++) begin
      chk("t3_data", out_data, lit[pp[i]]);
      if (i == 4) chk("t3_loop_count", loop_count, 1);
      @(negedge clk);
    end
    stop_play();
    play(MODE_PINGPONG, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t3b_data", out_data, 8'h11);
      chk("t3b_loop_count", loop_count, i);
      @(negedge clk);
    end
    stop_play();

    // Stop raised while stalled; the stalled beat is the last one.
    play(MODE_LOOP, 3);
    repeat (9) @(negedge clk);
    chk("t4_lc_before", loop_count, 2);
    out_ready = 1'b0; stop = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_stall_valid", out_valid, 1);
    stop = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid", out_valid, 0);
    chk("t4_done", done, 0);
    chk("t4_lc_kept", loop_count, 2);
    chk("t4_busy", busy, 0);

    // Oversized last_idx clamps to the final entry; out-of-range write ignored.
    play(MODE_LOOP, 15);
    repeat (DEPTH) @(negedge clk);
    chk("t5_wrap_data", out_data, 8'h11);
    chk("t5_wrap_lc", loop_count, 1);
    write_word(13, 8'hEE);
    stop_play();

    // Write to the entry being loaded: old word now, new word next pass.
    play(MODE_LOOP, 1);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = '0; wr_data = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t5_old_data", out_data, 8'h11);
    repeat (2) @(negedge clk);
    chk("t5_new_data", out_data, 8'h5A);
    stop_play();
    write_word(0, 8'h11);

    // Reset in the middle of playback; memory survives.
    play(MODE_ONESHOT, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_valid", out_valid, 0);
    chk("t6_lc", loop_count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_data", out_data, 0);
    rst = 1'b0;
    play(MODE_ONESHOT, 3);
    chk("t6_replay", out_data, 8'h11);
    repeat (5) @(negedge clk);

    // Saturation of the pass counter.
    play(MODE_LOOP, 0);
    repeat (300) @(negedge clk);
    chk("sat_lc", loop_count, 255);
    stop_play();
    repeat (2) @(negedge clk);
    chk("sat_lc_idle", loop_count, 255);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      wr_en     = ($urandom % 4 == 0);
      wr_addr   = AW'($urandom);
      wr_data   = 8'($urandom);
      start     = ($urandom % 8 == 0);
      stop      = ($urandom % 24 == 0);
      mode      = 2'($urandom);
      last_idx  = AW'($urandom);
      out_ready = ($urandom % 4 != 0);
      rst       = ($urandom % 500 == 0);
      @(negedge clk);
    end
    rst = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0;
    @(negedge clk);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
